// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch queue entry and fetch queue FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
    } fq_entry_t;

    typedef enum logic [1:0] {
        FQ_RUN   = 2'd0,
        FQ_STALL = 2'd1,
        FQ_HALT  = 2'd2
    } fq_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling queue between the icache and decode; drives the PC enable so
// the PC only advances when a word is captured or a redirect arrives.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      CLK,
    input  logic      RST,
    input  word_t     pc_addr,
    output logic      pcEN,
    output logic      imemREN,
    output word_t     imemaddr,
    input  logic      ihit,
    input  word_t     imemload,
    input  logic      flush,
    input  logic      halt,
    output logic      deq_valid,
    input  logic      deq_ready,
    output word_t     deq_instr,
    output word_t     deq_npc,
    output fq_state_t dbg_state_o,
    output logic [$clog2(DEPTH):0] dbg_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: an entry leaves the head only on a cycle where deq_valid
    // and deq_ready are both high and no effective flush is present.

    fq_state_t       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    fq_entry_t       mem_q [DEPTH];

    logic accept;
    logic pop;
    logic flush_eff;

    assign imemaddr  = pc_addr;
    assign deq_valid = (count_q != '0);
    assign deq_instr = mem_q[rd_ptr_q].instr;
    assign deq_npc   = mem_q[rd_ptr_q].npc;

    // Once halted, redirects no longer touch the queue so it can drain.
    assign flush_eff = flush && (state_q != FQ_HALT);
    assign accept    = imemREN && ihit;
    assign pop       = deq_valid && deq_ready && !flush_eff;
    assign pcEN      = accept || (flush && !RST);

    assign dbg_state_o = state_q;
    assign dbg_count_o = count_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FQ_RUN: begin
                if (halt) begin
                    state_d = FQ_HALT;
                end else if (flush) begin
                    state_d = FQ_RUN;
                end else if (count_d == CW'(DEPTH)) begin
                    state_d = FQ_STALL;
                end
            end
            FQ_STALL: begin
                if (halt) begin
                    state_d = FQ_HALT;
                end else if (flush || pop) begin
                    state_d = FQ_RUN;
                end
            end
            FQ_HALT: state_d = FQ_HALT;
            default: state_d = FQ_RUN;
        endcase
    end

    always_comb begin
        imemREN = 1'b0;
        if ((state_q == FQ_RUN) && !flush && !RST) begin
            imemREN = 1'b1;
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_eff) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d = count_q + CW'(accept) - CW'(pop);
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= '{instr: imemload, npc: pc_addr + 32'd4};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus hand-written
// reset and halt sequences, expected values worked out by hand.
module tb_fetch_queue;
    import cpu_types_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        ihit;
        logic [31:0] load;
        logic        flush;
        logic        halt;
        logic        rdy;
        logic        ren;
        logic        pcen;
        logic        dv;
        logic [31:0] instr;
        logic [31:0] npc;
        fq_state_t   st;
        logic [1:0]  cnt;
    } vec_t;

    logic      clk;
    logic      rst;
    word_t     pc_addr;
    logic      pc_en;
    logic      imem_ren;
    word_t     imem_addr;
    logic      ihit;
    word_t     imem_load;
    logic      flush;
    logic      halt;
    logic      deq_valid;
    logic      deq_ready;
    word_t     deq_instr;
    word_t     deq_npc;
    fq_state_t dbg_state;
    logic [1:0] dbg_count;

    int checks;
    int failures;

    fetch_queue #(.DEPTH(2)) dut (
        .CLK        (clk),
        .RST        (rst),
        .pc_addr    (pc_addr),
        .pcEN       (pc_en),
        .imemREN    (imem_ren),
        .imemaddr   (imem_addr),
        .ihit       (ihit),
        .imemload   (imem_load),
        .flush      (flush),
        .halt       (halt),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_instr  (deq_instr),
        .deq_npc    (deq_npc),
        .dbg_state_o(dbg_state),
        .dbg_count_o(dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic ih, input logic [31:0] ld,
                                input logic fl, input logic hl, input logic rdy,
                                input logic ren, input logic pcen, input logic dv,
                                input logic [31:0] instr, input logic [31:0] npc,
                                input fq_state_t st, input logic [1:0] cnt);
        vec_t v;
        v.pc = pc; v.ihit = ih; v.load = ld; v.flush = fl; v.halt = hl; v.rdy = rdy;
        v.ren = ren; v.pcen = pcen; v.dv = dv; v.instr = instr; v.npc = npc;
        v.st = st; v.cnt = cnt;
        return v;
    endfunction

    // Entered just after a falling edge; leaves at the next falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        pc_addr   = v.pc;
        ihit      = v.ihit;
        imem_load = v.load;
        flush     = v.flush;
        halt      = v.halt;
        deq_ready = v.rdy;
        #2;
        check("imemREN", idx, 32'(imem_ren), 32'(v.ren));
        check("pcEN", idx, 32'(pc_en), 32'(v.pcen));
        check("deq_valid", idx, 32'(deq_valid), 32'(v.dv));
        check("state", idx, 32'(dbg_state), 32'(v.st));
        check("count", idx, 32'(dbg_count), 32'(v.cnt));
        check("imemaddr", idx, imem_addr, v.pc);
        if (v.dv) begin
            check("deq_instr", idx, deq_instr, v.instr);
            check("deq_npc", idx, deq_npc, v.npc);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        pc_addr = '0; ihit = 1'b1; imem_load = 32'h2001_0001;
        flush = 1'b1; halt = 1'b0; deq_ready = 1'b1;

        // Straight-line fetch, icache miss run, fill to full, flushes, halt.
        vecs.push_back(mk(32'h0,   1, 32'h2001_0001, 0, 0, 1, 1, 1, 0, 0, 0, FQ_RUN, 0));
        vecs.push_back(mk(32'h4,   1, 32'h2002_0002, 0, 0, 1, 1, 1, 1, 32'h2001_0001, 32'h4, FQ_RUN, 1));
        vecs.push_back(mk(32'h8,   1, 32'h2003_0003, 0, 0, 1, 1, 1, 1, 32'h2002_0002, 32'h8, FQ_RUN, 1));
        vecs.push_back(mk(32'hC,   0, 32'h0,         0, 0, 1, 1, 0, 1, 32'h2003_0003, 32'hC, FQ_RUN, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(32'hC, 0, 32'h0, 0, 0, 1, 1, 0, 0, 0, 0, FQ_RUN, 0));
        vecs.push_back(mk(32'hC,   1, 32'hA1,        0, 0, 0, 1, 1, 0, 0, 0, FQ_RUN, 0));
        vecs.push_back(mk(32'h10,  1, 32'hA2,        0, 0, 0, 1, 1, 1, 32'hA1, 32'h10, FQ_RUN, 1));
        vecs.push_back(mk(32'h14,  1, 32'hA3,        0, 0, 0, 0, 0, 1, 32'hA1, 32'h10, FQ_STALL, 2));
        vecs.push_back(mk(32'h14,  1, 32'hA3,        0, 0, 1, 0, 0, 1, 32'hA1, 32'h10, FQ_STALL, 2));
        vecs.push_back(mk(32'h14,  1, 32'hA3,        0, 0, 0, 1, 1, 1, 32'hA2, 32'h14, FQ_RUN, 1));
        vecs.push_back(mk(32'h18,  0, 32'h0,         0, 0, 0, 0, 0, 1, 32'hA2, 32'h14, FQ_STALL, 2));
        vecs.push_back(mk(32'h18,  1, 32'hBAD,       1, 0, 1, 0, 1, 1, 32'hA2, 32'h14, FQ_STALL, 2));
        vecs.push_back(mk(32'h100, 1, 32'hC1,        0, 0, 0, 1, 1, 0, 0, 0, FQ_RUN, 0));
        vecs.push_back(mk(32'h104, 1, 32'hBAD2,      1, 0, 1, 0, 1, 1, 32'hC1, 32'h104, FQ_RUN, 1));
        vecs.push_back(mk(32'h200, 0, 32'h0,         0, 0, 1, 1, 0, 0, 0, 0, FQ_RUN, 0));
        vecs.push_back(mk(32'h200, 1, 32'hD1,        0, 0, 0, 1, 1, 0, 0, 0, FQ_RUN, 0));
        vecs.push_back(mk(32'h204, 1, 32'hD2,        0, 1, 0, 1, 1, 1, 32'hD1, 32'h204, FQ_RUN, 1));
        vecs.push_back(mk(32'h208, 1, 32'hD3,        1, 0, 0, 0, 1, 1, 32'hD1, 32'h204, FQ_HALT, 2));
        vecs.push_back(mk(32'h300, 1, 32'hD4,        0, 0, 1, 0, 0, 1, 32'hD1, 32'h204, FQ_HALT, 2));
        vecs.push_back(mk(32'h300, 1, 32'hD4,        0, 0, 1, 0, 0, 1, 32'hD2, 32'h208, FQ_HALT, 1));
        vecs.push_back(mk(32'h300, 1, 32'hD4,        0, 0, 1, 0, 0, 0, 0, 0, FQ_HALT, 0));

        @(negedge clk);
        #2;
        check("rst_deq_valid", 0, 32'(deq_valid), 32'h0);
        check("rst_imemREN", 0, 32'(imem_ren), 32'h0);
        check("rst_pcEN", 0, 32'(pc_en), 32'h0);
        check("rst_state", 0, 32'(dbg_state), 32'(FQ_RUN));
        check("rst_count", 0, 32'(dbg_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // PC wrap on npc, then flush and halt together from a one-entry queue.
        pulse_reset();
        run_vec(mk(32'hFFFF_FFFC, 1, 32'hE1, 0, 0, 0, 1, 1, 0, 0, 0, FQ_RUN, 0), 100);
        run_vec(mk(32'h0,   0, 32'h0, 1, 1, 1, 0, 1, 1, 32'hE1, 32'h0, FQ_RUN, 1), 101);
        run_vec(mk(32'h80,  1, 32'hE2, 0, 0, 1, 0, 0, 0, 0, 0, FQ_HALT, 0), 102);

        // Asynchronous reset between edges with one entry queued and a word in flight.
        pulse_reset();
        run_vec(mk(32'h40, 1, 32'hF1, 0, 0, 0, 1, 1, 0, 0, 0, FQ_RUN, 0), 200);
        pc_addr = 32'h44; ihit = 1'b1; imem_load = 32'hF2; flush = 1'b0; halt = 1'b0;
        deq_ready = 1'b0;
        #2;
        check("pre_rst_deq_valid", 201, 32'(deq_valid), 32'h1);
        check("pre_rst_instr", 201, deq_instr, 32'hF1);
        #1 rst = 1'b1;
        #1;
        check("async_deq_valid", 202, 32'(deq_valid), 32'h0);
        check("async_imemREN", 202, 32'(imem_ren), 32'h0);
        check("async_pcEN", 202, 32'(pc_en), 32'h0);
        check("async_count", 202, 32'(dbg_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(32'h44, 0, 32'h0, 0, 0, 1, 1, 0, 0, 0, 0, FQ_RUN, 0), 203);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 2, queue entries; power of two, at least 2.
REQ-002 CLK  in  1  system clock; all state changes on its rising edge.
REQ-003 RST  in  1  reset; asynchronous, active-high.
REQ-004 pc_addr  in  32  current PC from the PC stage (its imemaddr).
REQ-005 pcEN  out  1  advance/load enable to the PC stage.
REQ-006 imemREN  out  1  instruction read request to icache.
REQ-007 imemaddr  out  32  instruction read address.
REQ-008 ihit  in  1  icache returns a word this cycle.
REQ-009 imemload  in  32  instruction word, valid when ihit.
REQ-010 flush  in  1  redirect from execute (taken branch, j, jal, jr); PC takes the target this cycle.
REQ-011 halt  in  1  halt decoded downstream; stop fetching.
REQ-012 deq_valid  out  1  head entry valid to decode.
REQ-013 deq_ready  in  1  decode accepts head entry.
REQ-014 deq_instr  out  32  head entry instruction.
REQ-015 deq_npc  out  32  head entry fetch address + 4.

Function
REQ-016 imemaddr SHALL equal pc_addr combinationally.
REQ-017 FSM states SHALL be RUN, STALL, HALT.
REQ-018 imemREN SHALL be 1 only in RUN with flush=0, else 0.
REQ-019 Accept SHALL occur when imemREN=1 and ihit=1; it pushes {imemload, pc_addr+4} at the tail.
REQ-020 pcEN SHALL equal accept OR flush, so PC holds while waiting on icache and loads the target on flush.
REQ-021 Pop SHALL occur when deq_valid=1 and deq_ready=1 and flush=0.
REQ-022 deq_valid SHALL be 1 iff count>0; deq_instr/deq_npc read the head entry combinationally from registered storage.
REQ-023 Latency: a word accepted in cycle N SHALL be presented with deq_valid=1 in cycle N+1 when the queue was empty.
REQ-024 Push and pop in one cycle SHALL leave count unchanged and both pointers advance.
REQ-025 count SHALL range 0..DEPTH; pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1 bits.
REQ-026 RUN->STALL when the next count equals DEPTH; STALL->RUN on pop.
REQ-027 Push SHALL never occur at count=DEPTH; pop SHALL never occur at count=0.
REQ-028 flush SHALL, next cycle, clear count and both pointers and set state RUN, unless state is HALT.
REQ-029 A word returned (ihit=1) in a flush cycle SHALL be discarded; no push occurs.
REQ-030 flush and pop in the same cycle: flush wins; the entry is discarded, not delivered.
REQ-031 halt=1 in RUN or STALL SHALL move to HALT next cycle; the accept in the same cycle still completes.
REQ-032 In HALT, no requests; the queue continues to drain via pop; flush is ignored; exit only by RST.
REQ-033 flush and halt in the same cycle: state HALT, queue cleared.
REQ-034 pc_addr+4 SHALL be modulo 2^32 (0xFFFFFFFC -> npc 0x00000000).

Reset
REQ-035 RST=1 SHALL asynchronously set state RUN, count 0, pointers 0.
REQ-036 While RST=1: deq_valid=0, imemREN=0, pcEN=0; storage contents need not be cleared.
REQ-037 RST asserted mid-operation SHALL drop all queued entries and any in-flight icache word.
REQ-038 First request SHALL be issued in the first cycle after RST deasserts.

Structure
REQ-039 word_t SHALL come from cpu_types_pkg; fq_entry_t {word_t instr; word_t npc;} and the FSM enum fq_state_t SHALL be added to cpu_types_pkg.
REQ-040 Single module; no sub-module; storage is an array of fq_entry_t.

Verification
REQ-041 Reset, pc_addr=0, ihit=1 every cycle with imemload=0x20010001, 0x20020002, deq_ready=1 -> deq outputs 0x20010001/npc 0x4 then 0x20020002/npc 0x8 in consecutive cycles, pcEN=1 every cycle.
REQ-042 deq_ready=0, ihit=1 continuous, DEPTH=2 -> two accepts, state STALL, imemREN=0, pcEN=0; one pop -> RUN, next accept refills.
REQ-043 ihit=0 for 5 cycles -> imemREN=1, pcEN=0, pc_addr held, deq_valid=0 after queue empties.
REQ-044 Queue holding 2 entries, flush=1 with ihit=1 -> pcEN=1, word dropped, next cycle deq_valid=0, count 0.
REQ-045 halt=1 with 2 entries queued -> HALT, imemREN=0, both entries still delivered, flush afterwards ignored.
REQ-046 RST pulse asserted between clock edges with 1 entry queued -> deq_valid=0 immediately, not waiting for CLK.
